id_ex_skid_reg: RTL

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

---
 rtl/id_ex_skid_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: two-entry ID/EX skid buffer with flush and bubble insertion.
// Define PIPE_PERF_CNT_EN to add saturating stall_cnt / flush_cnt counters.
module id_ex_skid_reg #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic              inReadyQ;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;

    logic inTx;
    logic outTx;
    logic loadMain;
    logic loadSkid;
    logic moveSkid;
    logic clearMain;

    assign out_valid = (state != EMPTY);
    assign in_ready  = inReadyQ;
    assign out_ctrl  = mainCtrl;
    assign out_data  = mainData;

    assign inTx  = in_valid && inReadyQ;
    assign outTx = out_valid && out_ready;

    // in_ready is registered from the next state, so out_ready never
    // reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
        end else begin
            state    <= stateNext;
            inReadyQ <= (stateNext != FULL);
        end
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            unique case (1'b1)
                state == EMPTY: begin
                    if (inTx)
                        stateNext = ONE;
                end
                state == ONE: begin
                    if (inTx && !outTx)
                        stateNext = FULL;
                    else if (!inTx && outTx)
                        stateNext = EMPTY;
                end
                state == FULL: begin
                    if (outTx)
                        stateNext = ONE;
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    always_comb begin
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        moveSkid  = 1'b0;
        clearMain = 1'b0;
        unique case (1'b1)
            state == EMPTY: begin
                loadMain = inTx;
            end
            state == ONE: begin
                loadMain  = inTx && outTx;
                loadSkid  = inTx && !outTx;
                clearMain = outTx && !inTx;
            end
            state == FULL: begin
                moveSkid = outTx;
            end
            default: ;
        endcase
    end

    // Flush zeroes only control so a killed slot becomes a bubble;
    // data keeps its value to avoid toggling the wide operand bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            mainCtrl <= '0;
            mainData <= '0;
            skidCtrl <= '0;
            skidData <= '0;
        end else if (flush) begin
            mainCtrl <= '0;
            skidCtrl <= '0;
        end else begin
            if (loadMain) begin
                mainCtrl <= in_ctrl;
                mainData <= in_data;
            end else if (moveSkid) begin
                mainCtrl <= skidCtrl;
                mainData <= skidData;
                skidCtrl <= '0;
            end else if (clearMain) begin
                mainCtrl <= '0;
            end
            if (loadSkid) begin
                skidCtrl <= in_ctrl;
                skidData <= in_data;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stallHit;

    assign stallHit = out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallHit && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    // Counters compiled out; CNT_W stays for a uniform parameter list.
    if (CNT_W != 0) begin : gNoPerf
    end
`endif

endmodule
